// File: rtl/prach_hb5_pair.sv
// Pairs consecutive same-channel samples of a TDM stream into (dp1, dp2) for the
// PRACH half-band decimator, with channel-sequence checking and frame-sync tracking.
module prach_hb5_pair #(
   parameter int unsigned NumChannelUsed = 48,
   parameter int unsigned DataWidth      = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DataWidth-1:0] din_dq,
   input  logic                 din_dv,
   input  logic [7:0]           din_chn,
   input  logic                 sync_in,
   output logic [DataWidth-1:0] dout_dp1,
   output logic [DataWidth-1:0] dout_dp2,
   output logic                 dout_dv,
   output logic [7:0]           dout_chn,
   output logic                 sync_out,
   output logic                 err_seq
);

   localparam int unsigned     ChnW    = 8;
   localparam int unsigned     AddrW   = (NumChannelUsed > 1) ? $clog2(NumChannelUsed) : 1;
   localparam logic [ChnW-1:0] LastChn = ChnW'(NumChannelUsed - 1);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      EVEN     = 2'd1,
      ODD      = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ChnW-1:0]     r_exp_chn;
   logic [ChnW-1:0]     w_exp_chn_nxt;
   logic                r_sync_pend;
   logic                w_sync_pend_nxt;
   logic                w_err;
   logic                w_wr_en;
   logic                w_rd_en;
   logic                w_pair_sync;
   logic                w_wrap;
   logic                w_seq_bad;
   logic [ChnW-1:0]     w_chn_inc;
   logic [AddrW-1:0]    w_addr;

   logic [DataWidth-1:0] r_buf [NumChannelUsed];
   logic [DataWidth-1:0] r_rd_dq;
   logic                 r_p1_vld;
   logic                 r_p1_sync;
   logic [DataWidth-1:0] r_p1_dq;
   logic [ChnW-1:0]      r_p1_chn;

   assign w_addr    = din_chn[AddrW-1:0];
   assign w_wrap    = (din_chn == LastChn);
   assign w_chn_inc = w_wrap ? '0 : din_chn + ChnW'(1);
   assign w_seq_bad = (din_chn != r_exp_chn)
                    | (sync_in & (din_chn != '0))
                    | (32'(din_chn) >= NumChannelUsed);

   // Lock / phase / sequence tracking
   always_comb begin
      w_state_nxt     = r_state;
      w_exp_chn_nxt   = r_exp_chn;
      w_sync_pend_nxt = r_sync_pend;
      w_err           = 1'b0;
      w_wr_en         = 1'b0;
      w_rd_en         = 1'b0;
      w_pair_sync     = 1'b0;
      case (r_state)
         UNLOCKED: begin
            if (din_dv && sync_in && (din_chn == '0)) begin
               w_wr_en         = 1'b1;
               w_sync_pend_nxt = 1'b1;
               w_exp_chn_nxt   = w_chn_inc;
               w_state_nxt     = w_wrap ? ODD : EVEN;
            end
         end
         EVEN, ODD: begin
            if (din_dv) begin
               if (w_seq_bad) begin
                  w_err         = 1'b1;
                  w_exp_chn_nxt = '0;
                  w_state_nxt   = UNLOCKED;
               end else begin
                  w_exp_chn_nxt = w_chn_inc;
                  // A legal sync restarts the phase: this sample is always even
                  if (sync_in) begin
                     w_wr_en         = 1'b1;
                     w_sync_pend_nxt = 1'b1;
                     w_state_nxt     = w_wrap ? ODD : EVEN;
                  end else if (r_state == EVEN) begin
                     w_wr_en     = 1'b1;
                     w_state_nxt = w_wrap ? ODD : EVEN;
                  end else begin
                     w_rd_en     = 1'b1;
                     w_pair_sync = r_sync_pend && (din_chn == '0);
                     if (w_pair_sync) begin
                        w_sync_pend_nxt = 1'b0;
                     end
                     w_state_nxt = w_wrap ? EVEN : ODD;
                  end
               end
            end
         end
         default: begin
            w_state_nxt   = UNLOCKED;
            w_exp_chn_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= UNLOCKED;
         r_exp_chn   <= '0;
         r_sync_pend <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_exp_chn   <= w_exp_chn_nxt;
         r_sync_pend <= w_sync_pend_nxt;
      end
   end

   // Even-sample store with registered read; write and read never share an address in a frame
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_buf[w_addr] <= din_dq;
      end
      if (w_rd_en) begin
         r_rd_dq <= r_buf[w_addr];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p1_vld  <= 1'b0;
         r_p1_sync <= 1'b0;
         r_p1_dq   <= '0;
         r_p1_chn  <= '0;
      end else begin
         r_p1_vld  <= w_rd_en;
         r_p1_sync <= w_pair_sync;
         if (w_rd_en) begin
            r_p1_dq  <= din_dq;
            r_p1_chn <= din_chn;
         end
      end
   end

   // Output register; pair fields hold between pulses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_dv  <= 1'b0;
         sync_out <= 1'b0;
         err_seq  <= 1'b0;
         dout_dp1 <= '0;
         dout_dp2 <= '0;
         dout_chn <= '0;
      end else begin
         dout_dv  <= r_p1_vld;
         sync_out <= r_p1_sync;
         err_seq  <= w_err;
         if (r_p1_vld) begin
            dout_dp1 <= r_p1_dq;
            dout_dp2 <= r_rd_dq;
            dout_chn <= r_p1_chn;
         end
      end
   end

endmodule

// File: tb/tb_prach_hb5_pair.sv
// Directed bench for prach_hb5_pair: frame-level pairing model with per-cycle output
// comparison, plus hand-computed expectations for each scenario.
module tb_prach_hb5_pair;

   localparam int unsigned N    = 48;
   localparam int unsigned DW   = 16;
   localparam int          MAXC = 8192;

   logic          clk     = 1'b0;
   logic          rst     = 1'b1;
   logic [DW-1:0] din_dq  = '0;
   logic          din_dv  = 1'b0;
   logic [7:0]    din_chn = '0;
   logic          sync_in = 1'b0;
   logic [DW-1:0] dout_dp1;
   logic [DW-1:0] dout_dp2;
   logic          dout_dv;
   logic [7:0]    dout_chn;
   logic          sync_out;
   logic          err_seq;

   prach_hb5_pair #(
      .NumChannelUsed(N),
      .DataWidth     (DW)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .din_dq  (din_dq),
      .din_dv  (din_dv),
      .din_chn (din_chn),
      .sync_in (sync_in),
      .dout_dp1(dout_dp1),
      .dout_dp2(dout_dp2),
      .dout_dv (dout_dv),
      .dout_chn(dout_chn),
      .sync_out(sync_out),
      .err_seq (err_seq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_dv   = 0;
   int n_sync = 0;
   int n_err  = 0;

   // Expected outputs, indexed by the negedge at which they are observed
   bit            e_dv   [MAXC];
   bit            e_sync [MAXC];
   bit            e_err  [MAXC];
   logic [DW-1:0] e_dp1  [MAXC];
   logic [DW-1:0] e_dp2  [MAXC];
   logic [7:0]    e_chn  [MAXC];
   logic [DW-1:0] h_dp1 = '0;
   logic [DW-1:0] h_dp2 = '0;
   logic [7:0]    h_chn = '0;

   bit            m_locked = 1'b0;
   bit            m_odd    = 1'b0;
   bit            m_pend   = 1'b0;
   int            m_exp    = 0;
   logic [DW-1:0] m_buf [N];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic compare();
      bit xd;
      bit xs;
      bit xe;
      cyc++;
      xd = 1'b0;
      xs = 1'b0;
      xe = 1'b0;
      if (rst) begin
         h_dp1 = '0;
         h_dp2 = '0;
         h_chn = '0;
      end else if (cyc < MAXC) begin
         xd = e_dv[cyc];
         xs = e_sync[cyc];
         xe = e_err[cyc];
         if (xd) begin
            h_dp1 = e_dp1[cyc];
            h_dp2 = e_dp2[cyc];
            h_chn = e_chn[cyc];
         end
      end
      chk("dout_dv",  32'(dout_dv),  32'(xd));
      chk("sync_out", 32'(sync_out), 32'(xs));
      chk("err_seq",  32'(err_seq),  32'(xe));
      chk("dout_dp1", 32'(dout_dp1), 32'(h_dp1));
      chk("dout_dp2", 32'(dout_dp2), 32'(h_dp2));
      chk("dout_chn", 32'(dout_chn), 32'(h_chn));
      if (dout_dv)  n_dv++;
      if (sync_out) n_sync++;
      if (err_seq)  n_err++;
   endtask

   // Frame-level rules applied to one sampled input
   task automatic model_step();
      bit ok;
      int c;
      if (rst || !din_dv) return;
      c  = int'(din_chn);
      ok = 1'b0;
      if (!m_locked) begin
         ok = sync_in && (c == 0);
      end else if ((c != m_exp) || (sync_in && (c != 0)) || (c >= int'(N))) begin
         m_locked = 1'b0;
         m_exp    = 0;
         if (cyc + 1 < MAXC) e_err[cyc + 1] = 1'b1;
      end else begin
         ok = 1'b1;
      end
      if (ok) begin
         m_locked = 1'b1;
         if (sync_in) begin
            m_odd  = 1'b0;
            m_pend = 1'b1;
         end
         if (!m_odd) begin
            m_buf[c] = din_dq;
         end else if (cyc + 2 < MAXC) begin
            e_dv[cyc + 2]  = 1'b1;
            e_dp1[cyc + 2] = din_dq;
            e_dp2[cyc + 2] = m_buf[c];
            e_chn[cyc + 2] = din_chn;
            e_sync[cyc + 2] = m_pend && (c == 0);
            if (m_pend && (c == 0)) m_pend = 1'b0;
         end
         if (c == int'(N) - 1) begin
            m_exp = 0;
            m_odd = !m_odd;
         end else begin
            m_exp = c + 1;
         end
      end
   endtask

   task automatic model_reset();
      m_locked = 1'b0;
      m_odd    = 1'b0;
      m_pend   = 1'b0;
      m_exp    = 0;
      for (int i = cyc + 1; i < MAXC; i++) begin
         e_dv[i]   = 1'b0;
         e_sync[i] = 1'b0;
         e_err[i]  = 1'b0;
      end
   endtask

   // Drive at posedge+2, compare at negedge, model at the sampling posedge
   task automatic cycle(input bit dv, input bit sy, input int chn, input int dq);
      din_dv  = dv;
      sync_in = sy;
      din_chn = 8'(chn);
      din_dq  = DW'(dq);
      @(negedge clk);
      compare();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0);
   endtask

   task automatic send_frame(input int base, input bit sy, input int gap);
      for (int c = 0; c < int'(N); c++) begin
         cycle(1'b1, sy && (c == 0), c, base + c);
         idle(gap);
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      idle(2);
      rst = 1'b0;
      idle(2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s_dv;
      int s_sync;
      int s_err;

      // Reset state
      idle(3);
      chk("reset dout_dv",  32'(dout_dv),  32'd0);
      chk("reset dout_dp1", 32'(dout_dp1), 32'd0);
      chk("reset err_seq",  32'(err_seq),  32'd0);
      rst = 1'b0;
      idle(2);

      // Lock and pair, continuous input
      s_dv = n_dv; s_sync = n_sync; s_err = n_err;
      for (int k = 0; k < 4 * int'(N); k++) cycle(1'b1, k == 0, k % int'(N), k);
      idle(3);
      chk("lock pair count", 32'(n_dv - s_dv),     32'd96);
      chk("lock sync count", 32'(n_sync - s_sync), 32'd1);
      chk("lock err count",  32'(n_err - s_err),   32'd0);
      chk("lock last dp1",   32'(dout_dp1),        32'd191);
      chk("lock last dp2",   32'(dout_dp2),        32'd143);
      chk("lock last chn",   32'(dout_chn),        32'd47);

      // Pre-sync: unlocked input never produces output
      pulse_reset();
      s_dv = n_dv; s_err = n_err;
      for (int k = 0; k < 200; k++) cycle(1'b1, 1'b0, k % int'(N), k * 7);
      idle(3);
      chk("presync pair count", 32'(n_dv - s_dv),   32'd0);
      chk("presync err count",  32'(n_err - s_err), 32'd0);

      // Gapped input, dv every third cycle
      s_dv = n_dv; s_sync = n_sync;
      for (int k = 0; k < 4 * int'(N); k++) begin
         cycle(1'b1, k == 0, k % int'(N), k);
         idle(1);
         if (k == int'(N)) begin
            chk("gap first dv",   32'(dout_dv),  32'd1);
            chk("gap first sync", 32'(sync_out), 32'd1);
            chk("gap first dp1",  32'(dout_dp1), 32'd48);
            chk("gap first dp2",  32'(dout_dp2), 32'd0);
            chk("gap first chn",  32'(dout_chn), 32'd0);
         end
         idle(1);
      end
      idle(3);
      chk("gap pair count", 32'(n_dv - s_dv),     32'd96);
      chk("gap sync count", 32'(n_sync - s_sync), 32'd1);
      chk("gap last dp1",   32'(dout_dp1),        32'd191);

      // Channel skip in the odd frame, then recovery
      s_dv = n_dv; s_err = n_err;
      send_frame(1000, 1'b0, 0);
      for (int c = 0; c <= 5; c++) cycle(1'b1, 1'b0, c, 2000 + c);
      for (int c = 7; c < int'(N); c++) cycle(1'b1, 1'b0, c, 2000 + c);
      idle(3);
      chk("skip err count",  32'(n_err - s_err), 32'd1);
      chk("skip pair count", 32'(n_dv - s_dv),   32'd6);
      chk("skip last chn",   32'(dout_chn),      32'd5);
      chk("skip last dp1",   32'(dout_dp1),      32'd2005);
      s_dv = n_dv; s_sync = n_sync;
      send_frame(3000, 1'b1, 0);
      send_frame(4000, 1'b0, 0);
      idle(3);
      chk("recover pair count", 32'(n_dv - s_dv),     32'd48);
      chk("recover sync count", 32'(n_sync - s_sync), 32'd1);
      chk("recover last dp1",   32'(dout_dp1),        32'd4047);
      chk("recover last dp2",   32'(dout_dp2),        32'd3047);

      // Re-sync at the start of an odd frame restarts the phase
      s_dv = n_dv; s_sync = n_sync; s_err = n_err;
      send_frame(5000, 1'b0, 0);
      send_frame(6000, 1'b1, 0);
      chk("resync no pair yet", 32'(n_dv - s_dv), 32'd0);
      send_frame(7000, 1'b0, 0);
      idle(3);
      chk("resync pair count", 32'(n_dv - s_dv),     32'd48);
      chk("resync sync count", 32'(n_sync - s_sync), 32'd1);
      chk("resync err count",  32'(n_err - s_err),   32'd0);
      chk("resync last dp1",   32'(dout_dp1),        32'd7047);
      chk("resync last dp2",   32'(dout_dp2),        32'd6047);

      // Async reset right after the odd input for chn 10
      s_dv = n_dv;
      send_frame(8000, 1'b0, 0);
      for (int c = 0; c <= 10; c++) cycle(1'b1, 1'b0, c, 9000 + c);
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst dout_dv",  32'(dout_dv),  32'd0);
      chk("arst dout_dp1", 32'(dout_dp1), 32'd0);
      chk("arst dout_dp2", 32'(dout_dp2), 32'd0);
      chk("arst dout_chn", 32'(dout_chn), 32'd0);
      #1;
      idle(2);
      rst = 1'b0;
      idle(3);
      chk("arst pair count", 32'(n_dv - s_dv), 32'd9);
      s_dv = n_dv; s_err = n_err;
      send_frame(100, 1'b0, 0);
      send_frame(200, 1'b0, 0);
      idle(3);
      chk("arst unlocked pairs", 32'(n_dv - s_dv),   32'd0);
      chk("arst unlocked errs",  32'(n_err - s_err), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
